// File: rtl/tc_product_rescale_if.sv
// Valid/ready stream bundle for the product rescale stage: product in, rescaled result out.
interface tc_product_rescale_if #(
  parameter int unsigned OUT_W = 18
);
  logic             in_valid;
  logic             in_ready;
  logic [35:0]      in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  // Rescale stage side
  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat
  );

  // Producer/consumer side
  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );
endinterface

// File: rtl/tc_product_rescale.sv
// Rescales a 36-bit signed multiplier product: arithmetic right shift with round-half-up,
// saturation to OUT_W bits, 2-entry skid buffer on a valid/ready handshake, and a
// saturating count of clipped results accepted at the input.
module tc_product_rescale #(
  parameter int unsigned SHIFT = 10,
  parameter int unsigned OUT_W = 18,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  tc_product_rescale_if.slave  bus,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int unsigned ExtW = 37;
  // (1 << SHIFT) >> 1 is the rounding half-LSB, and collapses to zero when SHIFT is 0.
  localparam logic signed [ExtW-1:0] Half   = (37'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [ExtW-1:0] SatMax = (37'sd1 <<< (OUT_W - 1)) - 37'sd1;
  localparam logic signed [ExtW-1:0] SatMin = -(37'sd1 <<< (OUT_W - 1));

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  m_data_q, m_data_d;
  logic              m_sat_q, m_sat_d;
  logic [OUT_W-1:0]  s_data_q, s_data_d;
  logic              s_sat_q, s_sat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic signed [ExtW-1:0] ext;
  logic signed [ExtW-1:0] rnd;
  logic [OUT_W-1:0]       new_data;
  logic                   new_sat;
  logic                   in_ready_int;
  logic                   out_valid_int;
  logic                   in_xfer;
  logic                   out_xfer;

  // Round-and-saturate of the incoming product; 37 bits leave headroom for the rounding add.
  always_comb begin
    ext = {bus.in_prod[35], bus.in_prod};
    rnd = (ext + Half) >>> SHIFT;
    new_data = rnd[OUT_W-1:0];
    new_sat  = 1'b0;
    if (rnd > SatMax) begin
      new_data = SatMax[OUT_W-1:0];
      new_sat  = 1'b1;
    end else if (rnd < SatMin) begin
      new_data = SatMin[OUT_W-1:0];
      new_sat  = 1'b1;
    end
  end

  // Handshake flags decode from registered state only, so in_ready never sees out_ready.
  always_comb begin
    in_ready_int  = (state_q != StTwo);
    out_valid_int = (state_q != StEmpty);
    in_xfer       = bus.in_valid & in_ready_int;
    out_xfer      = out_valid_int & bus.out_ready;
  end

  // Skid-buffer next state: M always drives the outputs, S absorbs one item of backpressure.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_sat_d  = m_sat_q;
    s_data_d = s_data_q;
    s_sat_d  = s_sat_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_data_d = new_data;
          m_sat_d  = new_sat;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (in_xfer && !out_xfer) begin
          s_data_d = new_data;
          s_sat_d  = new_sat;
          state_d  = StTwo;
        end else if (in_xfer && out_xfer) begin
          m_data_d = new_data;
          m_sat_d  = new_sat;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_xfer) begin
          m_data_d = s_data_q;
          m_sat_d  = s_sat_q;
          s_data_d = '0;
          s_sat_d  = 1'b0;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Saturation event counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer && new_sat && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and data registers, cleared immediately by reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      m_sat_q  <= 1'b0;
      s_data_q <= '0;
      s_sat_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_sat_q  <= m_sat_d;
      s_data_q <= s_data_d;
      s_sat_q  <= s_sat_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = m_data_q;
  assign bus.out_sat   = m_sat_q;
  assign sat_count     = cnt_q;

endmodule

// File: tb/tb_tc_product_rescale.sv
// Self-checking bench for tc_product_rescale against a plain-arithmetic round/saturate model.
module tb_tc_product_rescale;

  localparam int SHIFT = 10;
  localparam int OUT_W = 18;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } item_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [CNT_W-1:0] sat_count;
  logic [1:0]       small_count;

  tc_product_rescale_if #(.OUT_W(OUT_W)) bus ();
  tc_product_rescale_if #(.OUT_W(OUT_W)) sbus ();

  tc_product_rescale #(.SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .bus       (bus),
    .sat_count (sat_count)
  );

  tc_product_rescale #(.SHIFT(SHIFT), .OUT_W(OUT_W), .CNT_W(2)) u_small (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .bus       (sbus),
    .sat_count (small_count)
  );

  always #5 ap_clk = ~ap_clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_sat_cnt = 0;
  item_t exp_q[$];

  // Reference: floor((p + 2^(SHIFT-1)) / 2^SHIFT), then clip to the signed OUT_W range.
  function automatic item_t model(input longint p);
    longint num, den, r, maxv, minv;
    item_t  it;
    num = p;
    den = 1;
    if (SHIFT > 0) begin
      num = p + (longint'(1) << (SHIFT - 1));
      den = longint'(1) << SHIFT;
    end
    r = num / den;
    if ((num % den) != 0 && num < 0) r = r - 1;
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    minv = -(longint'(1) << (OUT_W - 1));
    if (r > maxv) begin
      it.data = OUT_W'(maxv);
      it.sat  = 1'b1;
    end else if (r < minv) begin
      it.data = OUT_W'(minv);
      it.sat  = 1'b1;
    end else begin
      it.data = OUT_W'(r);
      it.sat  = 1'b0;
    end
    return it;
  endfunction

  function automatic longint rand_prod();
    longint v;
    case ($urandom_range(0, 3))
      0: begin
        v = longint'({$urandom, $urandom});
        v = (v <<< 28) >>> 28;
      end
      1: v = longint'($urandom_range(0, 32'h0FFF_FFFF)) - 64'sd134217728;
      2: v = (longint'($urandom_range(0, 511)) - 256) * 1024 + 512;
      default: begin
        case ($urandom_range(0, 3))
          0: v = -64'sd34359738368;
          1: v = 64'sd34359738367;
          2: v = -64'sd512;
          default: v = 64'sd0;
        endcase
      end
    endcase
    return v;
  endfunction

  function automatic void note_accept(input longint p);
    item_t it;
    it = model(p);
    exp_q.push_back(it);
    if (it.sat && exp_sat_cnt < CNT_MAX) exp_sat_cnt++;
  endfunction

  // One handshake cycle: drive at negedge, observe outputs before the rising edge.
  task automatic drive_cycle(input logic v, input longint p, input logic r,
                             output logic rdy, output logic vld,
                             output logic [OUT_W-1:0] d, output logic s);
    @(negedge ap_clk);
    bus.in_valid  = v;
    bus.in_prod   = p[35:0];
    bus.out_ready = r;
    #1;
    rdy = bus.in_ready;
    vld = bus.out_valid;
    d   = bus.out_data;
    s   = bus.out_sat;
    @(posedge ap_clk);
  endtask

  task automatic test_reset();
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data);
    end
    n_checks++;
    if (bus.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_sat: got %b expected 0", bus.out_sat);
    end
    n_checks++;
    if (sat_count !== '0) begin
      n_fail++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    exp_sat_cnt = 0;
    exp_q.delete();
    drive_cycle(1'b0, 0, 1'b1, rdy, vld, d, s);
    n_checks++;
    if (rdy !== 1'b1 || vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", rdy, vld);
    end
  endtask

  task automatic test_rounding();
    longint pv[5] = '{64'sd1536, -64'sd1536, 64'sd511, 64'sd512, 64'sd0};
    int     ev[4] = '{2, -1, 0, 1};
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i < 4, pv[i], 1'b1, rdy, vld, d, s);
      if (i < 4) note_accept(pv[i]);
      if (i > 0) begin
        n_checks++;
        if (vld !== 1'b1 || d !== OUT_W'(ev[i-1]) || s !== 1'b0) begin
          n_fail++;
          $display("FAIL round_%0d: valid=%b data=%0d sat=%b expected 1/%0d/0",
                   i - 1, vld, $signed(d), s, ev[i-1]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (sat_count !== CNT_W'(0)) begin
      n_fail++; $display("FAIL round_sat_count: got %0d expected 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    longint pv[3] = '{64'sd1073741824, -64'sd17179869184, 64'sd0};
    int     ev[2] = '{131071, -131072};
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(i < 2, pv[i], 1'b1, rdy, vld, d, s);
      if (i < 2) note_accept(pv[i]);
      if (i > 0) begin
        n_checks++;
        if (vld !== 1'b1 || d !== OUT_W'(ev[i-1]) || s !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_%0d: valid=%b data=%0d sat=%b expected 1/%0d/1",
                   i - 1, vld, $signed(d), s, ev[i-1]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (sat_count !== CNT_W'(2)) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 2", sat_count);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    longint p;
    item_t  e;
    int     got = 0;
    for (int i = 0; i <= 100; i++) begin
      p = rand_prod();
      drive_cycle(i < 100, p, 1'b1, rdy, vld, d, s);
      if (i < 100) begin
        n_checks++;
        if (rdy !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", i, rdy);
        end
        if (rdy === 1'b1) note_accept(p);
      end
      if (vld === 1'b1) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: data=%0d expected no output", $signed(d));
        end else begin
          e = exp_q.pop_front();
          if (d !== e.data || s !== e.sat) begin
            n_fail++;
            $display("FAIL b2b_data: got %0d/%b expected %0d/%b",
                     $signed(d), s, $signed(e.data), e.sat);
          end
        end
      end
    end
    n_checks++;
    if (got != 100 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs expected 100", got);
    end
    n_checks++;
    if (sat_count !== CNT_W'(exp_sat_cnt)) begin
      n_fail++; $display("FAIL b2b_sat_count: got %0d expected %0d", sat_count, exp_sat_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    longint p;
    item_t  e;
    int     acc = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      p = rand_prod();
      drive_cycle(1'b1, p, 1'b0, rdy, vld, d, s);
      if (rdy === 1'b1) begin
        acc++;
        note_accept(p);
      end
      if (i > 0) begin
        n_checks++;
        if (vld !== 1'b1 || d !== exp_q[0].data || s !== exp_q[0].sat) begin
          n_fail++;
          $display("FAIL bp_stable_%0d: got %b/%0d expected 1/%0d", i, vld, $signed(d),
                   $signed(exp_q[0].data));
        end
      end
    end
    n_checks++;
    if (acc != 2) begin
      n_fail++; $display("FAIL bp_accepted: got %0d expected 2", acc);
    end
    n_checks++;
    if (rdy !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", rdy);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 0, 1'b1, rdy, vld, d, s);
      e = exp_q.pop_front();
      n_checks++;
      if (vld !== 1'b1 || d !== e.data || s !== e.sat) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got %b/%0d/%b expected 1/%0d/%b", i, vld, $signed(d), s,
                 $signed(e.data), e.sat);
      end
      n_checks++;
      if (rdy !== logic'(i == 1)) begin
        n_fail++; $display("FAIL bp_ready_return_%0d: got %b expected %0d", i, rdy, i == 1);
      end
    end
    drive_cycle(1'b0, 0, 1'b1, rdy, vld, d, s);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: out_valid=%b expected 0", vld);
    end
  endtask

  task automatic test_random_handshake();
    logic rdy, vld, s, v, r;
    logic [OUT_W-1:0] d;
    logic [OUT_W-1:0] prev_d = '0;
    logic   prev_s = 1'b0;
    logic   prev_stall = 1'b0;
    longint cur_p;
    item_t  e;
    int     sent = 0;
    int     got = 0;
    exp_q.delete();
    cur_p = rand_prod();
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      v = (sent < 10000) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      drive_cycle(v, cur_p, r, rdy, vld, d, s);
      if (prev_stall) begin
        n_checks++;
        if (vld !== 1'b1 || d !== prev_d || s !== prev_s) begin
          n_fail++;
          $display("FAIL rnd_stable: got %b/%0d/%b expected 1/%0d/%b", vld, $signed(d), s,
                   $signed(prev_d), prev_s);
        end
      end
      if (v && rdy === 1'b1) begin
        note_accept(cur_p);
        sent++;
        cur_p = rand_prod();
      end
      if (vld === 1'b1 && r) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: data=%0d expected no output", $signed(d));
        end else begin
          e = exp_q.pop_front();
          if (d !== e.data || s !== e.sat) begin
            n_fail++;
            $display("FAIL rnd_data_%0d: got %0d/%b expected %0d/%b", got, $signed(d), s,
                     $signed(e.data), e.sat);
          end
        end
      end
      prev_stall = (vld === 1'b1) && !r;
      prev_d = d;
      prev_s = s;
    end
    n_checks++;
    if (got != 10000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_count: got %0d outputs expected 10000", got);
    end
    n_checks++;
    if (sat_count !== CNT_W'(exp_sat_cnt)) begin
      n_fail++; $display("FAIL rnd_sat_count: got %0d expected %0d", sat_count, exp_sat_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic rdy, vld, s;
    logic [OUT_W-1:0] d;
    longint p;
    item_t  e;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 64'sd1073741824, 1'b0, rdy, vld, d, s);
    end
    #2;
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || sat_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b sat_count=%0d expected 0/0", bus.out_valid,
               sat_count);
    end
    n_checks++;
    if (bus.out_data !== '0 || bus.out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_data: got %0d/%b expected 0/0", bus.out_data, bus.out_sat);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    exp_q.delete();
    exp_sat_cnt = 0;
    p = rand_prod();
    drive_cycle(1'b1, p, 1'b1, rdy, vld, d, s);
    n_checks++;
    if (rdy !== 1'b1 || vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_ready: in_ready=%b out_valid=%b expected 1/0", rdy, vld);
    end
    note_accept(p);
    drive_cycle(1'b0, 0, 1'b1, rdy, vld, d, s);
    e = exp_q.pop_front();
    n_checks++;
    if (vld !== 1'b1 || d !== e.data || s !== e.sat) begin
      n_fail++;
      $display("FAIL post_reset_item: got %b/%0d/%b expected 1/%0d/%b", vld, $signed(d), s,
               $signed(e.data), e.sat);
    end
    drive_cycle(1'b0, 0, 1'b1, rdy, vld, d, s);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_stale: out_valid=%b expected 0", vld);
    end
  endtask

  task automatic test_small_counter();
    int exp_c;
    for (int k = 1; k <= 5; k++) begin
      @(negedge ap_clk);
      sbus.in_valid = 1'b1;
      sbus.in_prod  = 36'h0_4000_0000;
      @(posedge ap_clk);
      #1;
      exp_c = (k > 3) ? 3 : k;
      n_checks++;
      if (small_count !== 2'(exp_c)) begin
        n_fail++; $display("FAIL small_count_%0d: got %0d expected %0d", k, small_count, exp_c);
      end
    end
    @(negedge ap_clk);
    sbus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_prod    = '0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_prod   = '0;
    sbus.out_ready = 1'b1;
    test_reset();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_random_handshake();
    test_async_reset();
    test_small_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_product_rescale.md
Name: tc_product_rescale

Overview:
- Pipelined output stage placed directly downstream of the 18x18 signed, 36-bit-product multiplier in the TrackletCalculator datapath.
- Takes the raw 36-bit signed product and arithmetically right-shifts it by a fixed amount with round-half-up.
- Saturates the result to the narrower fixed-point width used by the next calculation step.
- Decouples producer and consumer with a valid/ready handshake and a 2-entry skid buffer, and counts saturation events for monitoring.

Parameters:
- SHIFT, 10, arithmetic right-shift applied to the product (0..20); when 0, no rounding is applied.
- OUT_W, 18, signed output width (8..36).
- CNT_W, 16, width of the saturation event counter.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  36  signed product from the multiplier.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_W  rescaled, saturated signed result.
- out_sat  out  1  out_data was clipped (travels with out_data).
- sat_count  out  CNT_W  number of saturated results accepted at the input since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - Applies immediately; all storage is cleared.
  - out_valid=0, out_data=0, out_sat=0, sat_count=0.
  - Any in-flight or buffered data is discarded; no partial transfer is completed.
  - After release, in_ready=1 from the first clock edge.
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both 1 on a clock edge.
  - Output transfer occurs when out_valid and out_ready are both 1 on a clock edge.
- Arithmetic, computed combinationally on in_prod and registered at input transfer:
  - ext = sign-extend in_prod to 37 bits.
  - If SHIFT>0: r = (ext + 2^(SHIFT-1)) >>> SHIFT. If SHIFT=0: r = ext.
  - Saturation bounds: max = 2^(OUT_W-1)-1, min = -2^(OUT_W-1).
  - If r > max: data = max, sat = 1. If r < min: data = min, sat = 1. Otherwise data = r[OUT_W-1:0], sat = 0.
  - Round-half-up means ties round toward +infinity (e.g. -1.5 becomes -1).
- Storage: a main register M (drives the outputs) and a skid register S, each holding {data, sat, valid}.
- State machine:
  - EMPTY (M and S empty):
    - in_ready=1, out_valid=0.
    - Input transfer loads M and moves to ONE.
  - ONE (M full, S empty):
    - in_ready=1, out_valid=1.
    - Input transfer without output transfer: load S, move to TWO.
    - Input and output transfer together: load M with the new item, stay in ONE.
    - Output transfer only: move to EMPTY.
  - TWO (M and S full):
    - in_ready=0, out_valid=1.
    - Output transfer: copy S to M, clear S, move to ONE.
- Timing and ordering:
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N when the block was EMPTY.
  - Sustained throughput is 1 item per cycle while out_ready=1.
  - Output order equals input order; no item is dropped or duplicated.
- Output stability: out_data and out_sat hold stable while out_valid=1 and out_ready=0.
- in_ready is a registered function of state only and has no combinational path from out_ready.
- When out_valid=0, out_data and out_sat keep their last value.
- sat_count:
  - Increments on each input transfer whose computed sat=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by ap_rst.

Test Plan:
- SHIFT=10, OUT_W=18, out_ready=1; send in_prod = 1536, -1536, 511, 512 -> out_data = 2, -1, 0, 1 one cycle after each accept; out_sat=0; sat_count=0.
- Send in_prod = 2^30 and then -2^34 -> out_data = 131071 with out_sat=1, then -131072 with out_sat=1; sat_count=2.
- Back-to-back stream of 100 random products with out_ready=1 -> in_ready remains 1, 100 outputs in order, each matching the reference round-and-saturate model.
- Hold out_ready=0 and drive in_valid=1 -> exactly 2 items accepted, then in_ready=0 and out_data stable. Raise out_ready -> both items emerge in order and in_ready returns to 1 one cycle after the first output transfer.
- Random in_valid/out_ready toggling over 10k items -> scoreboard sees no loss, duplication or reordering; out_data never changes while out_valid=1 and out_ready=0.
- Assert ap_rst asynchronously mid-clock while in TWO -> out_valid and sat_count drop to 0 immediately with no clock edge needed; after release, in_ready=1 and the first new item is output correctly with no stale data.
- With CNT_W=2, inject 5 saturating products -> sat_count reads 1, 2, 3, 3, 3.
